io_bus_ctrl: RTL and testbench
==============================

// Module: io_bus_ctrl
// PURPOSE
//  Wishbone-classic slave to external memory / IO strobe bus controller; the
//  request-side counterpart of the read-data return mux. Decodes each cycle
//  (wb_tga_i: 0=memory, 1=IO), drives MEMCS_N/IOCS0_N/IOCS1_N, RDN/WRN,
//  latched address and write data, and times wb_ack_o with wait states.
//  Read data returns through the separate read-data mux while RDN is low.
// PARAMETERS
//  MEM_WAIT  2      extra strobe cycles for memory cycles (0..15)
//  IO_WAIT   4      minimum extra strobe cycles for IO cycles (0..15)
//  IO0_BASE  8'h00  wb_adr_i[15:8] match for IOCS0_N
//  IO1_BASE  8'h01  wb_adr_i[15:8] match for IOCS1_N
//  TIMEOUT   64     IORDY wait limit in cycles (IO_TIMEOUT_EN only)
// PORTS
//  wb_clk_i    in   1   clock; all logic on rising edge
//  wb_rst_n_i  in   1   synchronous reset, active low
//  wb_cyc_i    in   1   bus cycle valid
//  wb_stb_i    in   1   strobe
//  wb_we_i     in   1   1=write, 0=read
//  wb_tga_i    in   1   address tag: 0=memory, 1=IO
//  wb_adr_i    in   16  address
//  wb_dat_i    in   16  write data
//  wb_ack_o    out  1   cycle ack, one-cycle pulse
//  wb_err_o    out  1   error pulse (IO_TIMEOUT_EN only; else tied 0)
//  IORDY       in   1   IO device ready, active high
//  ADDR        out  16  latched address to memory/IO
//  DATW        out  16  latched write data
//  MEMCS_N     out  1   memory chip select, active low
//  IOCS0_N     out  1   IO device 0 select, active low
//  IOCS1_N     out  1   IO device 1 select, active low
//  RDN         out  1   read strobe, active low
//  WRN         out  1   write strobe, active low
// BEHAVIOUR
//  - Reset (wb_rst_n_i=0 at edge): state IDLE; ADDR=0, DATW=0, all _N
//    outputs 1, wb_ack_o=0, wb_err_o=0, wait counter 0. Mid-cycle reset
//    deasserts all strobes at that edge, no ack issued.
//  - All outputs registered. FSM: IDLE -> SETUP -> STROBE -> ACK -> IDLE.
//  - IDLE: on cyc&stb, latch adr/dat/we/tga into ADDR/DATW/internals;
//    go SETUP. Chip select decode: tga=0 -> MEMCS_N; tga=1 and
//    adr[15:8]==IO0_BASE -> IOCS0_N; ==IO1_BASE -> IOCS1_N (IO0 wins if
//    equal); IO with no match -> no CS, cycle still completes normally.
//  - SETUP (1 cycle): CS low, RDN/WRN high; load counter with MEM_WAIT or
//    IO_WAIT; go STROBE.
//  - STROBE: RDN low (read) or WRN low (write). Decrement counter to 0;
//    leave when counter==0 and (memory cycle or IORDY==1) -> ACK.
//    Strobe width = WAIT+1 cycles minimum; IORDY low extends indefinitely.
//  - ACK (1 cycle): wb_ack_o=1; CS stays low; read: RDN stays low (data
//    valid at mux during ack); write: WRN returns high (1-cycle hold).
//    Next state IDLE with all strobes high.
//  - Latency: request sampled edge N -> wb_ack_o high in cycle
//    N+3+WAIT (no IORDY stretch). Back-to-back: new request accepted in
//    IDLE the cycle after ACK; min one idle cycle between strobes.
//  - Abort: wb_cyc_i=0 in SETUP/STROBE -> IDLE next edge, strobes high,
//    no ack/err.
//  - RDN and WRN never low simultaneously; at most one CS low at a time.
// CONFIGURATION
//  IO_TIMEOUT_EN defined: in STROBE of an IO cycle, a cycle counter
//    saturates at TIMEOUT; if IORDY still 0, go ACK state but pulse
//    wb_err_o=1 instead of wb_ack_o (strobes released as in ACK).
//  IO_TIMEOUT_EN undefined: no timeout counter; IO cycles wait for IORDY
//    forever; wb_err_o tied 0.
// TESTING
//  - Mem read, tga=0, adr=16'h1234, MEM_WAIT=2 -> MEMCS_N low 5 cycles,
//    RDN low 4, ADDR=16'h1234, ack at N+5, one pulse.
//  - IO write, tga=1, adr=16'h0105, dat=16'hBEEF, IORDY=1 -> IOCS1_N low,
//    WRN low IO_WAIT+1=5 cycles, DATW=16'hBEEF, ack at N+7; IOCS0_N high.
//  - IO read adr=16'h0010, IORDY low 10 cycles after SETUP -> RDN held low
//    until IORDY=1 plus ack cycle; single ack.
//  - Back-to-back mem write then read, cyc/stb held -> one idle cycle,
//    two acks, never RDN&WRN low together.
//  - cyc dropped in STROBE / reset mid-STROBE -> all _N high next edge,
//    no ack; next request completes normally.
//  - IO_TIMEOUT_EN, IORDY stuck 0 -> wb_err_o pulse after TIMEOUT=64
//    cycles, no ack; without macro -> no err, stays in STROBE.

Source files
------------

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: Wishbone-classic slave driving a memory / IO chip-select and strobe bus.
// Define IO_TIMEOUT_EN to bound IORDY waits and answer a stuck IO cycle with wb_err_o.
module io_bus_ctrl #(
   parameter int unsigned MEM_WAIT = 2,
   parameter int unsigned IO_WAIT  = 4,
   parameter logic [7:0]  IO0_BASE = 8'h00,
   parameter logic [7:0]  IO1_BASE = 8'h01,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic        wb_tga_i,
   input  logic [15:0] wb_adr_i,
   input  logic [15:0] wb_dat_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   input  logic        IORDY,
   output logic [15:0] ADDR,
   output logic [15:0] DATW,
   output logic        MEMCS_N,
   output logic        IOCS0_N,
   output logic        IOCS1_N,
   output logic        RDN,
   output logic        WRN
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

   state_t     state;
   logic       we_q;
   logic       io_q;
   logic [3:0] wait_cnt;
   logic       io0_hit;
   logic       io1_hit;
   logic       release_bus;

   if (MEM_WAIT > 15 || IO_WAIT > 15 || TIMEOUT == 0) begin : g_param_check
      $error("io_bus_ctrl: wait states must be 0..15 and TIMEOUT nonzero");
   end

   // IO0 takes priority when both bases are programmed to the same page.
   assign io0_hit = (wb_adr_i[15:8] == IO0_BASE);
   assign io1_hit = (wb_adr_i[15:8] == IO1_BASE) && !io0_hit;

   assign release_bus = (state == ACK) ||
                        (((state == SETUP) || (state == STROBE)) && !wb_cyc_i);

`ifdef IO_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt;
   logic            timed_out;

   assign timed_out = (to_cnt == TO_W'(TIMEOUT));
`else
   assign wb_err_o = 1'b0;
`endif

   // Single registered FSM: every bus-facing output changes only on a clock edge.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state    <= IDLE;
         ADDR     <= '0;
         DATW     <= '0;
         MEMCS_N  <= 1'b1;
         IOCS0_N  <= 1'b1;
         IOCS1_N  <= 1'b1;
         RDN      <= 1'b1;
         WRN      <= 1'b1;
         wb_ack_o <= 1'b0;
         we_q     <= 1'b0;
         io_q     <= 1'b0;
         wait_cnt <= '0;
`ifdef IO_TIMEOUT_EN
         wb_err_o <= 1'b0;
         to_cnt   <= '0;
`endif
      end else begin
         wb_ack_o <= 1'b0;
`ifdef IO_TIMEOUT_EN
         wb_err_o <= 1'b0;
`endif
         if (release_bus) begin
            state    <= IDLE;
            MEMCS_N  <= 1'b1;
            IOCS0_N  <= 1'b1;
            IOCS1_N  <= 1'b1;
            RDN      <= 1'b1;
            WRN      <= 1'b1;
            wait_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (wb_cyc_i && wb_stb_i) begin
                     ADDR    <= wb_adr_i;
                     DATW    <= wb_dat_i;
                     we_q    <= wb_we_i;
                     io_q    <= wb_tga_i;
                     MEMCS_N <= wb_tga_i;
                     IOCS0_N <= !(wb_tga_i && io0_hit);
                     IOCS1_N <= !(wb_tga_i && io1_hit);
                     state   <= SETUP;
                  end
               end
               SETUP: begin
                  wait_cnt <= io_q ? 4'(IO_WAIT) : 4'(MEM_WAIT);
                  RDN      <= we_q;
                  WRN      <= !we_q;
                  state    <= STROBE;
`ifdef IO_TIMEOUT_EN
                  to_cnt   <= '0;
`endif
               end
               STROBE: begin
`ifdef IO_TIMEOUT_EN
                  if (io_q && !timed_out) to_cnt <= to_cnt + 1'b1;
`endif
                  // Write data is held one cycle past WRN by releasing it on entry to ACK.
                  if (wait_cnt != 4'd0) begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end else if (!io_q || IORDY) begin
                     state    <= ACK;
                     wb_ack_o <= 1'b1;
                     WRN      <= 1'b1;
                  end
`ifdef IO_TIMEOUT_EN
                  else if (timed_out) begin
                     state    <= ACK;
                     wb_err_o <= 1'b1;
                     WRN      <= 1'b1;
                  end
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed and randomized transactions for io_bus_ctrl, checked against
// a cycle-count model of wait states, IORDY stretching and chip-select decode.
module tb_io_bus_ctrl;

   localparam int unsigned MEM_WAIT = 2;
   localparam int unsigned IO_WAIT  = 4;
   localparam logic [7:0]  IO0_BASE = 8'h00;
   localparam logic [7:0]  IO1_BASE = 8'h01;
   localparam int unsigned TIMEOUT  = 64;
   localparam int          BOUND    = 200;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_n_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic        wb_tga_i;
   logic [15:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        IORDY;
   logic [15:0] ADDR;
   logic [15:0] DATW;
   logic        MEMCS_N;
   logic        IOCS0_N;
   logic        IOCS1_N;
   logic        RDN;
   logic        WRN;

   int checks   = 0;
   int failures = 0;

   int          ack_idx;
   int          ack_cnt;
   int          err_cnt;
   int          mem_low;
   int          io0_low;
   int          io1_low;
   int          rdn_low;
   int          wrn_low;
   int          overlap;
   logic [15:0] addr_at_ack;
   logic [15:0] datw_at_ack;

   io_bus_ctrl #(
      .MEM_WAIT(MEM_WAIT),
      .IO_WAIT (IO_WAIT),
      .IO0_BASE(IO0_BASE),
      .IO1_BASE(IO1_BASE),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_n_i(wb_rst_n_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_we_i   (wb_we_i),
      .wb_tga_i  (wb_tga_i),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_ack_o  (wb_ack_o),
      .wb_err_o  (wb_err_o),
      .IORDY     (IORDY),
      .ADDR      (ADDR),
      .DATW      (DATW),
      .MEMCS_N   (MEMCS_N),
      .IOCS0_N   (IOCS0_N),
      .IOCS1_N   (IOCS1_N),
      .RDN       (RDN),
      .WRN       (WRN)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cycles are numbered from the request-sampling edge: cycle 1 is setup, strobe starts
   // at cycle 2 and lasts at least WAIT+1 cycles, then stretches while IORDY is low.
   function automatic int expectedAck(input logic tga, input int low);
      int strobe_end;
      if (!tga) return 3 + MEM_WAIT;
      strobe_end = (low + 1 > 2 + IO_WAIT) ? low + 1 : 2 + IO_WAIT;
      return strobe_end + 1;
   endfunction

   // 0 = no select, 1 = memory, 2 = IO0, 3 = IO1
   function automatic int expectedSel(input logic tga, input logic [15:0] adr);
      if (!tga) return 1;
      if (adr[15:8] == IO0_BASE) return 2;
      if (adr[15:8] == IO1_BASE) return 3;
      return 0;
   endfunction

   // IORDY is low for cycles 1..low and high afterwards.
   task automatic applyStimulus(input logic we, input logic tga, input logic [15:0] adr,
                                input logic [15:0] dat, input int low,
                                input bit chained, input bit drop_at_ack);
      int cs_cnt;
      ack_idx = 0; ack_cnt = 0; err_cnt = 0; mem_low = 0; io0_low = 0; io1_low = 0;
      rdn_low = 0; wrn_low = 0; overlap = 0; addr_at_ack = 'x; datw_at_ack = 'x;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_tga_i = tga;
      wb_adr_i = adr; wb_dat_i = dat; IORDY = (low == 0);
      if (chained) begin
         @(negedge wb_clk_i);
         checkOutput("b2b_idle_strobes", {MEMCS_N, IOCS0_N, IOCS1_N, RDN, WRN, wb_ack_o}, 6'b111110);
      end
      for (int i = 1; i <= BOUND; i++) begin
         @(negedge wb_clk_i);
         cs_cnt = 0;
         if (MEMCS_N === 1'b0) begin mem_low++; cs_cnt++; end
         if (IOCS0_N === 1'b0) begin io0_low++; cs_cnt++; end
         if (IOCS1_N === 1'b0) begin io1_low++; cs_cnt++; end
         if (RDN === 1'b0) rdn_low++;
         if (WRN === 1'b0) wrn_low++;
         if ((RDN === 1'b0 && WRN === 1'b0) || cs_cnt > 1) overlap++;
         if (wb_err_o === 1'b1) err_cnt++;
         if (wb_ack_o === 1'b1) begin
            ack_cnt++;
            if (ack_idx == 0) begin
               ack_idx     = i;
               addr_at_ack = ADDR;
               datw_at_ack = DATW;
               if (drop_at_ack) begin
                  wb_cyc_i = 1'b0;
                  wb_stb_i = 1'b0;
               end else begin
                  break;
               end
            end
         end
         IORDY = (i > low);
         if (ack_idx != 0 && i >= ack_idx + 2) break;
      end
      if (drop_at_ack) begin
         wb_cyc_i = 1'b0;
         wb_stb_i = 1'b0;
      end
   endtask

   task automatic checkTransaction(input string tag, input logic we, input logic tga,
                                   input logic [15:0] adr, input logic [15:0] dat, input int low);
      int exp_ack;
      int sel;
      exp_ack = expectedAck(tga, low);
      sel     = expectedSel(tga, adr);
      checkOutput($sformatf("%s_ack_cycle", tag), ack_idx, exp_ack);
      checkOutput($sformatf("%s_ack_count", tag), ack_cnt, 1);
      checkOutput($sformatf("%s_err_count", tag), err_cnt, 0);
      checkOutput($sformatf("%s_memcs_low", tag), mem_low, (sel == 1) ? exp_ack : 0);
      checkOutput($sformatf("%s_iocs0_low", tag), io0_low, (sel == 2) ? exp_ack : 0);
      checkOutput($sformatf("%s_iocs1_low", tag), io1_low, (sel == 3) ? exp_ack : 0);
      checkOutput($sformatf("%s_rdn_low", tag), rdn_low, we ? 0 : exp_ack - 1);
      checkOutput($sformatf("%s_wrn_low", tag), wrn_low, we ? exp_ack - 2 : 0);
      checkOutput($sformatf("%s_overlap", tag), overlap, 0);
      checkOutput($sformatf("%s_addr", tag), addr_at_ack, adr);
      checkOutput($sformatf("%s_datw", tag), datw_at_ack, dat);
   endtask

   initial begin
      logic        r_we;
      logic        r_tga;
      logic [15:0] r_adr;
      logic [15:0] r_dat;
      int          r_low;
      int          hi_pick;

      wb_rst_n_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_tga_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0; IORDY = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      checkOutput("reset_strobes", {MEMCS_N, IOCS0_N, IOCS1_N, RDN, WRN}, 5'b11111);
      checkOutput("reset_ack_err", {wb_ack_o, wb_err_o}, 2'b00);
      checkOutput("reset_addr", ADDR, 16'h0000);
      checkOutput("reset_datw", DATW, 16'h0000);
      wb_rst_n_i = 1'b1;
      @(negedge wb_clk_i);

      $display("[TB] memory read and IO write");
      applyStimulus(1'b0, 1'b0, 16'h1234, 16'h0000, 0, 1'b0, 1'b1);
      checkTransaction("mem_rd", 1'b0, 1'b0, 16'h1234, 16'h0000, 0);
      applyStimulus(1'b1, 1'b1, 16'h0105, 16'hBEEF, 0, 1'b0, 1'b1);
      checkTransaction("io_wr", 1'b1, 1'b1, 16'h0105, 16'hBEEF, 0);

      $display("[TB] IORDY stretch, unmatched IO page, IORDY ignored on memory");
      applyStimulus(1'b0, 1'b1, 16'h0010, 16'h5555, 10, 1'b0, 1'b1);
      checkTransaction("io_rd_stretch", 1'b0, 1'b1, 16'h0010, 16'h5555, 10);
      applyStimulus(1'b1, 1'b1, 16'h7F00, 16'h0F0F, 0, 1'b0, 1'b1);
      checkTransaction("io_nomatch", 1'b1, 1'b1, 16'h7F00, 16'h0F0F, 0);
      applyStimulus(1'b0, 1'b0, 16'hC0DE, 16'h1357, 8, 1'b0, 1'b1);
      checkTransaction("mem_iordy_low", 1'b0, 1'b0, 16'hC0DE, 16'h1357, 8);

      $display("[TB] back-to-back write then read");
      applyStimulus(1'b1, 1'b0, 16'h2000, 16'h1111, 0, 1'b0, 1'b0);
      checkTransaction("b2b_wr", 1'b1, 1'b0, 16'h2000, 16'h1111, 0);
      applyStimulus(1'b0, 1'b0, 16'h2002, 16'h2222, 0, 1'b1, 1'b1);
      checkTransaction("b2b_rd", 1'b0, 1'b0, 16'h2002, 16'h2222, 0);

      $display("[TB] abort in strobe");
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = 1'b0;
      wb_adr_i = 16'h4444; wb_dat_i = 16'h0;
      repeat (3) @(negedge wb_clk_i);
      checkOutput("abort_rdn_active", RDN, 1'b0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("abort_released", {MEMCS_N, IOCS0_N, IOCS1_N, RDN, WRN, wb_ack_o}, 6'b111110);
      ack_cnt = 0;
      repeat (4) begin
         @(negedge wb_clk_i);
         if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) ack_cnt++;
      end
      checkOutput("abort_no_ack", ack_cnt, 0);

      $display("[TB] reset in strobe");
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_tga_i = 1'b0;
      wb_adr_i = 16'hA5A5; wb_dat_i = 16'h5A5A;
      repeat (3) @(negedge wb_clk_i);
      checkOutput("rst_mid_wrn_active", WRN, 1'b0);
      wb_rst_n_i = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("rst_mid_released", {MEMCS_N, IOCS0_N, IOCS1_N, RDN, WRN, wb_ack_o}, 6'b111110);
      checkOutput("rst_mid_addr", ADDR, 16'h0000);
      checkOutput("rst_mid_datw", DATW, 16'h0000);
      wb_rst_n_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge wb_clk_i);
      applyStimulus(1'b1, 1'b1, 16'h0033, 16'h7777, 3, 1'b0, 1'b1);
      checkTransaction("after_rst", 1'b1, 1'b1, 16'h0033, 16'h7777, 3);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 12; n++) begin
         r_we    = 1'($urandom_range(0, 1));
         r_tga   = 1'($urandom_range(0, 1));
         hi_pick = $urandom_range(0, 3);
         r_adr   = 16'($urandom);
         if (hi_pick == 0) r_adr[15:8] = IO0_BASE;
         else if (hi_pick == 1) r_adr[15:8] = IO1_BASE;
         r_dat   = 16'($urandom);
         r_low   = $urandom_range(0, 12);
         applyStimulus(r_we, r_tga, r_adr, r_dat, r_low, 1'b0, 1'b1);
         checkTransaction($sformatf("rand%0d", n), r_we, r_tga, r_adr, r_dat, r_low);
      end

      $display("[TB] IORDY stuck low");
      IORDY = 1'b0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_tga_i = 1'b1;
      wb_adr_i = 16'h0020; wb_dat_i = 16'h0;
      ack_cnt = 0; err_cnt = 0;
`ifdef IO_TIMEOUT_EN
      for (int i = 0; i < TIMEOUT + IO_WAIT + 20; i++) begin
         @(negedge wb_clk_i);
         if (wb_ack_o === 1'b1) ack_cnt++;
         if (wb_err_o === 1'b1) begin
            err_cnt++;
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
         end
      end
      checkOutput("timeout_err_pulse", err_cnt, 1);
      checkOutput("timeout_no_ack", ack_cnt, 0);
      checkOutput("timeout_released", {MEMCS_N, IOCS0_N, IOCS1_N, RDN, WRN}, 5'b11111);
`else
      repeat (100) begin
         @(negedge wb_clk_i);
         if (wb_ack_o === 1'b1) ack_cnt++;
         if (wb_err_o === 1'b1) err_cnt++;
      end
      checkOutput("stuck_no_ack", ack_cnt, 0);
      checkOutput("stuck_no_err", err_cnt, 0);
      checkOutput("stuck_rdn_held", {IOCS0_N, RDN}, 2'b00);
      IORDY = 1'b1;
      @(negedge wb_clk_i);
      checkOutput("stuck_release_ack", wb_ack_o, 1'b1);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("stuck_idle_after", {IOCS0_N, RDN, wb_ack_o}, 3'b110);
`endif
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
